nibble_serial_adder: RTL



---
 rtl/arith_pkg.sv | 19 +
 rtl/add4_slice.sv | 31 +++
 rtl/nibble_serial_adder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: definitions shared by the nibble-serial arithmetic blocks.
//   state_t      - control FSM states (IDLE, RUN, DONE)
//   NIBBLE_W     - width of one serial slice step (4 bits)
//   nibbles_for  - number of slice steps needed for a given operand width
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

  function automatic int unsigned nibbles_for(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/add4_slice.sv
// add4_slice: purely combinational 4-bit carry-select adder slice.
//   x, y : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out
// Both carry-in cases are computed up front and ci only drives the final
// select, keeping the carry input off the adder's internal ripple path.
module add4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] r0;
  logic [4:0] r1;

  always_comb begin
    r0 = {1'b0, x} + {1'b0, y};
    r1 = {1'b0, x} + {1'b0, y} + 5'd1;
    if (ci) begin
      s  = r1[3:0];
      co = r1[4];
    end else begin
      s  = r0[3:0];
      co = r0[4];
    end
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands 4 bits per clock using a
// single add4_slice, with the inter-nibble carry held in a register.
// Result latency is WIDTH/4 cycles from the accepting edge.
//
// Parameters:
//   WIDTH      operand/sum width, multiple of 4 and >= 4 (default 16)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (a, b, cin captured on accept)
//   a, b, cin            operands and carry into nibble 0
//   out_valid, out_ready result handshake
//   sum, cout            registered result a+b+cin mod 2^WIDTH, carry out
//   busy                 high while an operation is in RUN or DONE
// Build option:
//   NIBBLE_SERIAL_ADDER_SUB_EN adds input 'sub'; when set on accept the
//   block computes a-b (B inverted, carry forced to 1, cin ignored) and
//   cout=1 means no borrow.
module nibble_serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIBBLES = nibbles_for(WIDTH);
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [3:0]       slice_s;
  logic             slice_co;
  logic [WIDTH+NIBBLE_W-1:0] sum_cat;
  logic [WIDTH-1:0] sum_shift;

  add4_slice u_slice (
    .x  (a_q[3:0]),
    .y  (b_q[3:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Operand conditioning at capture time.
  always_comb begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    b_in = sub ? ~b : b;
    c_in = sub ? 1'b1 : cin;
`else
    b_in = b;
    c_in = cin;
`endif
  end

  // New nibble enters at the top; after NIBBLES steps the first nibble
  // has walked down to bit 0. Concatenate-then-slice keeps this valid
  // for WIDTH=4, where there is nothing below the new nibble.
  always_comb begin
    sum_cat   = {slice_s, sum_q};
    sum_shift = sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = RUN;
      RUN:     if (idx_q == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= c_in;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_shift;
          carry_q <= slice_co;
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          idx_q   <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule
